// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N_REQ valid/ready producers.
// A grant lasts up to MAX_BURST accepted beats. A full FIFO stalls the burst but does not end it.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic                      i_fifo_full,
    output logic                      o_fifo_wr,
    output logic [DATA_W-1:0]         o_fifo_data,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   owner_idx;
    logic [DATA_W-1:0]  owner_data;
    logic               busy;
    logic               owner_valid;
    logic               accept;
    logic               release_now;

    // First valid requester strictly after base, wrapping N_REQ-1 -> 0; base itself is checked last.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                                 input logic [IDX_W-1:0] base);
        logic [N_REQ-1:0] g;
        logic             found;
        int unsigned      j;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            j = 32'(base) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && v[j[IDX_W-1:0]]) begin
                g[j[IDX_W-1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        owner_idx  = '0;
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx  = IDX_W'(i);
                owner_data = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign busy        = (state_q == BUSY);
    assign o_busy      = busy;
    assign o_grant     = grant_q;
    assign o_req_ready = busy ? (grant_q & {N_REQ{~i_fifo_full}}) : '0;
    assign o_fifo_wr   = |(i_req_valid & o_req_ready);
    assign o_fifo_data = o_fifo_wr ? owner_data : '0;

    assign owner_valid = |(i_req_valid & grant_q);
    assign accept      = busy & owner_valid & ~i_fifo_full;
    assign release_now = busy & (~owner_valid | (accept & (cnt_q == CNT_W'(MAX_BURST - 1))));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|i_req_valid) begin
                    state_d = BUSY;
                    grant_d = rr_pick(i_req_valid, last_q);
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    last_d = owner_idx;
                    cnt_d  = '0;
                    // Re-arbitrate in the same cycle so the next owner sees ready without a bubble.
                    if (|i_req_valid) begin
                        grant_d = rr_pick(i_req_valid, owner_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_W=16, MAX_BURST=4).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_data;
    logic [N-1:0]    grant;
    logic            busy;

    int checks;
    int failures;

    fifo_wr_arbiter #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .MAX_BURST(4)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req_valid(req_valid),
        .i_req_data (req_data),
        .o_req_ready(req_ready),
        .i_fifo_full(fifo_full),
        .o_fifo_wr  (fifo_wr),
        .o_fifo_data(fifo_data),
        .o_grant    (grant),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned idx, input logic [DW-1:0] v);
        req_data[idx*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== 4'b0000) begin
                failures++; $display("FAIL reset_grant cyc=%0d got=%b exp=0000", c, grant);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, busy);
            end
            checks++;
            if (fifo_wr !== 1'b0 || fifo_data !== 16'h0000) begin
                failures++; $display("FAIL reset_wr cyc=%0d got wr=%b data=%h exp wr=0 data=0000", c, fifo_wr, fifo_data);
            end
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, req_ready);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 16'd1);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin
            failures++; $display("FAIL single_latency got grant=%b wr=%b exp grant=0000 wr=0", grant, fifo_wr);
        end
        next_cycle();
        for (int b = 1; b <= 5; b++) begin
            @(negedge clk);
            checks++;
            if (grant !== 4'b0010 || req_ready !== 4'b0010) begin
                failures++; $display("FAIL single_grant beat=%0d got grant=%b ready=%b exp 0010/0010", b, grant, req_ready);
            end
            checks++;
            if (fifo_wr !== 1'b1 || fifo_data !== 16'(b)) begin
                failures++; $display("FAIL single_data beat=%0d got wr=%b data=%h exp wr=1 data=%h", b, fifo_wr, fifo_data, 16'(b));
            end
            next_cycle();
            set_data(1, 16'(b + 1));
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (fifo_wr !== 1'b0 || grant !== 4'b0010) begin
            failures++; $display("FAIL single_drop got wr=%b grant=%b exp wr=0 grant=0010", fifo_wr, grant);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL single_idle got grant=%b busy=%b exp 0000/0", grant, busy);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        logic [N-1:0] eg;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 16'h0A00 | 16'(i));
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            failures++; $display("FAIL fair_first got grant=%b exp=0000", grant);
        end
        next_cycle();
        for (int b = 0; b < 20; b++) begin
            eg = 4'b0001 << ((b / 4) % 4);
            @(negedge clk);
            checks++;
            if (grant !== eg || req_ready !== eg) begin
                failures++; $display("FAIL fair_grant beat=%0d got grant=%b ready=%b exp=%b", b, grant, req_ready, eg);
            end
            checks++;
            if (fifo_wr !== 1'b1 || fifo_data !== (16'h0A00 | 16'((b / 4) % 4))) begin
                failures++; $display("FAIL fair_data beat=%0d got wr=%b data=%h exp wr=1 data=%h", b, fifo_wr, fifo_data, 16'h0A00 | 16'((b / 4) % 4));
            end
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_valid = 4'b0100;
        set_data(2, 16'h0021);
        next_cycle();
        for (int b = 1; b <= 4; b++) begin
            if (b == 3) begin
                fifo_full = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checks++;
                    if (fifo_wr !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0100) begin
                        failures++; $display("FAIL bp_stall cyc=%0d got wr=%b ready=%b grant=%b exp 0/0000/0100", s, fifo_wr, req_ready, grant);
                    end
                    next_cycle();
                end
                fifo_full = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (fifo_wr !== 1'b1 || fifo_data !== (16'h0020 | 16'(b)) || grant !== 4'b0100) begin
                failures++; $display("FAIL bp_beat beat=%0d got wr=%b data=%h grant=%b exp 1/%h/0100", b, fifo_wr, fifo_data, grant, 16'h0020 | 16'(b));
            end
            next_cycle();
            set_data(2, 16'h0020 | 16'(b + 1));
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (fifo_wr !== 1'b0) begin
            failures++; $display("FAIL bp_nowr got wr=%b exp=0", fifo_wr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_release got grant=%b busy=%b exp 0000/0", grant, busy);
        end
        next_cycle();
    endtask

    task automatic test_early_drop();
        do_reset();
        req_valid = 4'b1001;
        set_data(0, 16'd7);
        set_data(3, 16'h0033);
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || fifo_wr !== 1'b1 || fifo_data !== 16'd7) begin
            failures++; $display("FAIL drop_first got grant=%b wr=%b data=%h exp 0001/1/0007", grant, fifo_wr, fifo_data);
        end
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (fifo_wr !== 1'b0 || fifo_data !== 16'h0000 || grant !== 4'b0001) begin
            failures++; $display("FAIL drop_release got wr=%b data=%h grant=%b exp 0/0000/0001", fifo_wr, fifo_data, grant);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b1000 || fifo_wr !== 1'b1 || fifo_data !== 16'h0033) begin
            failures++; $display("FAIL drop_regrant got grant=%b wr=%b data=%h exp 1000/1/0033", grant, fifo_wr, fifo_data);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 16'h0051);
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0010 || fifo_wr !== 1'b1 || fifo_data !== 16'h0051) begin
            failures++; $display("FAIL rst_pre got grant=%b wr=%b data=%h exp 0010/1/0051", grant, fifo_wr, fifo_data);
        end
        next_cycle();
        set_data(1, 16'h0052);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (fifo_wr !== 1'b0 || grant !== 4'b0000 || req_ready !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_async got wr=%b grant=%b ready=%b busy=%b exp 0/0000/0000/0", fifo_wr, grant, req_ready, busy);
        end
        @(negedge clk);
        next_cycle();
        checks++;
        if (fifo_wr !== 1'b0 || grant !== 4'b0000) begin
            failures++; $display("FAIL rst_hold got wr=%b grant=%b exp 0/0000", fifo_wr, grant);
        end
        rstn      = 1'b1;
        req_valid = 4'b0011;
        set_data(0, 16'h0050);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin
            failures++; $display("FAIL rst_idle got grant=%b wr=%b exp 0000/0", grant, fifo_wr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001 || fifo_wr !== 1'b1 || fifo_data !== 16'h0050) begin
            failures++; $display("FAIL rst_priority got grant=%b wr=%b data=%h exp 0001/1/0050", grant, fifo_wr, fifo_data);
        end
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #3;
        test_reset();
        test_single_burst();
        test_fairness();
        test_back_pressure();
        test_early_drop();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
